systolic_pingpong_ctrl: RTL and testbench

Sequencing controller for the 2-bit-spike × int8-weight systolic PE array. Owns the two weight banks in every PE (`weight_LoadPtr` / `weight_CalcPtr`), loads the next weight tile into the idle bank row by row, and streams row-skewed activation vectors through the array using the active bank. Releases the active bank only after the psum pipeline has drained. Sits between the tile fetch/DMA logic and the systolic array instance.

---
 rtl/systolic_pingpong_ctrl_pkg.sv | 31 +++
 rtl/systolic_pingpong_ctrl_act_skew_buf.sv | 47 ++++
 rtl/systolic_pingpong_ctrl.sv | 155 +++++++++++++++
 tb/tb_systolic_pingpong_ctrl.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pingpong_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pingpong_ctrl_pkg
// Description : Shared state encodings and drain-latency floor for the
//               systolic ping-pong weight/activation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pingpong_ctrl_pkg;

    typedef logic [0:0] lstate_t;
    typedef logic [1:0] cstate_t;

    // Weight-load state machine
    localparam lstate_t L_IDLE   = 1'b0;
    localparam lstate_t L_LOAD   = 1'b1;

    // Activation-stream state machine
    localparam cstate_t C_IDLE   = 2'd0;
    localparam cstate_t C_STREAM = 2'd1;
    localparam cstate_t C_DRAIN  = 2'd2;

    // Extra cycles beyond the row skew plus column ripple before a bank is safe to release
    localparam int DRAIN_LAT_MARGIN = 2;

    // Smallest drain latency that still covers the last psum leaving the array
    function automatic int drain_lat_min(input int rows, input int cols);
        return rows + cols + DRAIN_LAT_MARGIN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pingpong_ctrl_act_skew_buf.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pingpong_ctrl_act_skew_buf
// Description : Row-skew buffer for activation vectors. Lane r is delayed by
//               r+1 cycles so each PE row sees its operand one step after
//               the row above it.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_pingpong_ctrl_act_skew_buf #(
    parameter int ARRAY_ROWS = 16,
    parameter int DATA_W     = 8
) (
    input  logic                         s_clk,
    input  logic                         s_rst,
    input  logic                         in_valid,
    input  logic [ARRAY_ROWS*DATA_W-1:0] in_data,
    output logic [ARRAY_ROWS-1:0]        out_valid,
    output logic [ARRAY_ROWS*DATA_W-1:0] out_data
);

    for (genvar lane = 0; lane < ARRAY_ROWS; lane++) begin : g_lane
        logic [lane:0]     r_vld;
        logic [DATA_W-1:0] r_dat [lane+1];

        // Shift valid and lane data through lane+1 stages; idle slots carry zero data
        always_ff @(posedge s_clk or posedge s_rst) begin
            if (s_rst) begin
                r_vld <= '0;
                for (int i = 0; i <= lane; i++) begin
                    r_dat[i] <= '0;
                end
            end else begin
                r_vld[0] <= in_valid;
                r_dat[0] <= in_valid ? in_data[DATA_W*lane +: DATA_W] : '0;
                for (int i = 1; i <= lane; i++) begin
                    r_vld[i] <= r_vld[i-1];
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end

        assign out_valid[lane]                  = r_vld[lane];
        assign out_data[DATA_W*lane +: DATA_W]  = r_dat[lane];
    end

endmodule
`default_nettype wire

// File: rtl/systolic_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pingpong_ctrl
// Description : Ping-pong weight bank sequencer for the 2-bit-spike x int8
//               systolic array. Loads the idle bank row by row while the
//               active bank streams skewed activations, and hands a bank back
//               only after its psums have drained.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_pingpong_ctrl
    import systolic_pingpong_ctrl_pkg::*;
#(
    parameter int ARRAY_ROWS = 16,
    parameter int ARRAY_COLS = 16,
    parameter int DATA_W     = 8,
    parameter int DRAIN_LAT  = 2*ARRAY_ROWS + ARRAY_COLS
) (
    input  logic                         s_clk,
    input  logic                         s_rst,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [ARRAY_COLS*8-1:0]      w_data,
    input  logic                         act_valid,
    output logic                         act_ready,
    input  logic                         act_last,
    input  logic [ARRAY_ROWS*DATA_W-1:0] act_data,
    output logic                         weight_load_ptr,
    output logic                         weight_calc_ptr,
    output logic [ARRAY_ROWS-1:0]        w_row_valid,
    output logic [ARRAY_COLS*8-1:0]      w_row_data,
    output logic [ARRAY_ROWS-1:0]        a_row_valid,
    output logic [ARRAY_ROWS*DATA_W-1:0] a_row_data,
    output logic                         tile_done,
    output logic                         busy
);

    localparam int ROW_W     = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
    // A too-short drain parameter is raised to the floor so a bank is never released under live psums
    localparam int DRAIN_MIN = drain_lat_min(ARRAY_ROWS, ARRAY_COLS);
    localparam int DRAIN_CYC = (DRAIN_LAT < DRAIN_MIN) ? DRAIN_MIN : DRAIN_LAT;
    localparam int DCNT_W    = $clog2(DRAIN_CYC + 1);

    lstate_t            r_lstate;
    lstate_t            w_lstate_nxt;
    cstate_t            r_cstate;
    cstate_t            w_cstate_nxt;
    logic [1:0]         r_full;
    logic               r_load_bank;
    logic               r_calc_bank;
    logic [ROW_W-1:0]   r_row_cnt;
    logic [DCNT_W-1:0]  r_drain_cnt;

    logic               w_w_fire;
    logic               w_a_fire;
    logic               w_load_done;
    logic               w_drain_done;

    assign w_w_fire     = w_valid & w_ready;
    assign w_a_fire     = act_valid & act_ready;
    assign w_load_done  = w_w_fire & (r_row_cnt == ROW_W'(ARRAY_ROWS - 1));
    assign w_drain_done = (r_cstate == C_DRAIN) & (r_drain_cnt == DCNT_W'(DRAIN_CYC - 1));

    // Load FSM state register
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) r_lstate <= L_IDLE;
        else       r_lstate <= w_lstate_nxt;
    end

    // Load FSM next state: start a tile once the target bank is empty, stop after its last row
    always_comb begin
        w_lstate_nxt = r_lstate;
        case (r_lstate)
            L_IDLE:  if (!r_full[r_load_bank]) w_lstate_nxt = L_LOAD;
            L_LOAD:  if (w_load_done)          w_lstate_nxt = L_IDLE;
            default:                           w_lstate_nxt = L_IDLE;
        endcase
    end

    // Load FSM outputs
    always_comb begin
        w_ready = (r_lstate == L_LOAD);
    end

    // Calc FSM state register
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) r_cstate <= C_IDLE;
        else       r_cstate <= w_cstate_nxt;
    end

    // Calc FSM next state: stream until act_last, then drain for the fixed latency
    always_comb begin
        w_cstate_nxt = r_cstate;
        case (r_cstate)
            C_IDLE:   if (w_a_fire)            w_cstate_nxt = act_last ? C_DRAIN : C_STREAM;
            C_STREAM: if (w_a_fire && act_last) w_cstate_nxt = C_DRAIN;
            C_DRAIN:  if (w_drain_done)         w_cstate_nxt = C_IDLE;
            default:                            w_cstate_nxt = C_IDLE;
        endcase
    end

    // Calc FSM outputs: a new tile may only start on a fully loaded bank
    always_comb begin
        act_ready = ((r_cstate == C_IDLE) & r_full[r_calc_bank]) | (r_cstate == C_STREAM);
    end

    // Bank bookkeeping, row/drain counters and registered array-facing strobes
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_full          <= '0;
            r_load_bank     <= 1'b0;
            r_calc_bank     <= 1'b0;
            r_row_cnt       <= '0;
            r_drain_cnt     <= '0;
            w_row_valid     <= '0;
            w_row_data      <= '0;
            weight_load_ptr <= 1'b0;
            tile_done       <= 1'b0;
        end else begin
            // Load and calc always target different banks, so both updates may land together
            if (w_load_done) begin
                r_full[r_load_bank] <= 1'b1;
                r_load_bank         <= ~r_load_bank;
            end
            if (w_drain_done) begin
                r_full[r_calc_bank] <= 1'b0;
                r_calc_bank         <= ~r_calc_bank;
            end
            if (w_w_fire) begin
                r_row_cnt  <= w_load_done ? '0 : r_row_cnt + ROW_W'(1);
                w_row_data <= w_data;
            end
            r_drain_cnt     <= (r_cstate == C_DRAIN) ? r_drain_cnt + DCNT_W'(1) : '0;
            w_row_valid     <= w_w_fire ? (ARRAY_ROWS'(1) << r_row_cnt) : '0;
            weight_load_ptr <= r_load_bank;
            tile_done       <= w_drain_done;
        end
    end

    assign weight_calc_ptr = r_calc_bank;
    assign busy            = (|r_full) | (r_cstate != C_IDLE);

    systolic_pingpong_ctrl_act_skew_buf #(
        .ARRAY_ROWS (ARRAY_ROWS),
        .DATA_W     (DATA_W)
    ) u_act_skew_buf (
        .s_clk     (s_clk),
        .s_rst     (s_rst),
        .in_valid  (w_a_fire),
        .in_data   (act_data),
        .out_valid (a_row_valid),
        .out_data  (a_row_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_systolic_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_pingpong_ctrl
// Description : Self-checking bench for systolic_pingpong_ctrl (4x4 array,
//               drain latency 12) with a time-stamped reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_pingpong_ctrl;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 8;
    localparam int DL = 12;

    logic              s_clk = 1'b0;
    logic              s_rst = 1'b1;
    logic              w_valid = 1'b0;
    logic              w_ready;
    logic [C*8-1:0]    w_data = '0;
    logic              act_valid = 1'b0;
    logic              act_ready;
    logic              act_last = 1'b0;
    logic [R*DW-1:0]   act_data = '0;
    logic              weight_load_ptr;
    logic              weight_calc_ptr;
    logic [R-1:0]      w_row_valid;
    logic [C*8-1:0]    w_row_data;
    logic [R-1:0]      a_row_valid;
    logic [R*DW-1:0]   a_row_data;
    logic              tile_done;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 s_clk = ~s_clk;

    systolic_pingpong_ctrl #(
        .ARRAY_ROWS (R),
        .ARRAY_COLS (C),
        .DATA_W     (DW),
        .DRAIN_LAT  (DL)
    ) dut (
        .s_clk           (s_clk),
        .s_rst           (s_rst),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_data          (w_data),
        .act_valid       (act_valid),
        .act_ready       (act_ready),
        .act_last        (act_last),
        .act_data        (act_data),
        .weight_load_ptr (weight_load_ptr),
        .weight_calc_ptr (weight_calc_ptr),
        .w_row_valid     (w_row_valid),
        .w_row_data      (w_row_data),
        .a_row_valid     (a_row_valid),
        .a_row_data      (a_row_data),
        .tile_done       (tile_done),
        .busy            (busy)
    );

    // ---------------- reference model ----------------
    int          cyc = 0;
    bit          m_full [2];
    bit          m_lbank, m_cbank, m_loading;
    int          m_row, m_phase, m_release;   // phase: 0 idle, 1 streaming, 2 draining
    logic [R-1:0]   e_wrv;
    logic [C*8-1:0] e_wrd;
    bit          e_lptr, e_done;
    bit          s_v [32][R];                 // expected lane valid, indexed by cycle mod 32
    logic [DW-1:0] s_d [32][R];

    function automatic void mreset();
        m_full[0] = 0; m_full[1] = 0;
        m_lbank = 0; m_cbank = 0; m_loading = 0;
        m_row = 0; m_phase = 0; m_release = 0;
        e_wrv = '0; e_wrd = '0; e_lptr = 0; e_done = 0;
        for (int i = 0; i < 32; i++)
            for (int r = 0; r < R; r++) begin
                s_v[i][r] = 0;
                s_d[i][r] = '0;
            end
    endfunction

    function automatic bit m_act_ready();
        return (m_phase == 0 && m_full[m_cbank]) || m_phase == 1;
    endfunction

    function automatic bit m_busy();
        return m_full[0] || m_full[1] || m_phase != 0;
    endfunction

    // Apply this cycle's handshakes to the model, then move to the next cycle
    task automatic advance();
        bit wf, af;
        int slot;
        wf   = w_valid && m_loading;
        af   = act_valid && m_act_ready();
        slot = cyc % 32;
        for (int r = 0; r < R; r++) s_v[slot][r] = 0;
        if (af)
            for (int r = 0; r < R; r++) begin
                s_v[(cyc + 1 + r) % 32][r] = 1;
                s_d[(cyc + 1 + r) % 32][r] = act_data[DW*r +: DW];
            end
        e_wrv  = wf ? R'(1 << m_row) : '0;
        if (wf) e_wrd = w_data;
        e_lptr = m_lbank;
        e_done = 0;
        if (!m_loading) m_loading = !m_full[m_lbank];
        else if (wf && m_row == R-1) m_loading = 0;
        if (wf) begin
            if (m_row == R-1) begin
                m_full[m_lbank] = 1;
                m_lbank = !m_lbank;
                m_row = 0;
            end else m_row++;
        end
        if (m_phase == 2 && cyc + 1 == m_release) begin
            m_full[m_cbank] = 0;
            m_cbank = !m_cbank;
            m_phase = 0;
            e_done = 1;
        end else if (af) begin
            if (act_last) begin
                m_phase = 2;
                m_release = cyc + 1 + DL;
            end else m_phase = 1;
        end
        cyc++;
        @(posedge s_clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        s_rst = 1; w_valid = 1; act_valid = 1; act_last = 1;
        w_data = 32'hFFFF_FFFF; act_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge s_clk);
        @(negedge s_clk);
        n_tests++;
        if ({w_ready, act_ready, weight_load_ptr, weight_calc_ptr, tile_done, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {w_ready, act_ready, weight_load_ptr, weight_calc_ptr, tile_done, busy});
        end
        n_tests++;
        if (w_row_valid !== '0 || a_row_valid !== '0) begin
            n_fail++;
            $display("FAIL reset_valids: got w=%b a=%b want 0", w_row_valid, a_row_valid);
        end
        n_tests++;
        if (w_row_data !== '0 || a_row_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got w=%h a=%h want 0", w_row_data, a_row_data);
        end
        w_valid = 0; act_valid = 0; act_last = 0; w_data = '0; act_data = '0;
        @(posedge s_clk); #1;
        s_rst = 0;
        mreset();
    endtask

    task automatic test_no_bank();
        for (int n = 0; n < 8; n++) begin
            act_valid = 1; act_last = n[0]; act_data = $urandom;
            @(negedge s_clk);
            n_tests++;
            if (act_ready !== 1'b0 || a_row_valid !== '0) begin
                n_fail++;
                $display("FAIL no_bank: got act_ready=%b a_row_valid=%b want 0/0", act_ready, a_row_valid);
            end
            advance();
        end
        act_valid = 0; act_last = 0;
    endtask

    task automatic test_weight_load();
        int k = 0;
        int beat_c [8];
        w_valid = 1;
        for (int n = 0; n < 14; n++) begin
            w_data = $urandom;
            @(negedge s_clk);
            n_tests++;
            if (w_ready !== m_loading) begin
                n_fail++;
                $display("FAIL wload_ready: cyc %0d got %b want %b", cyc, w_ready, m_loading);
            end
            if (w_row_valid !== '0 && k < 8) begin
                beat_c[k] = cyc;
                n_tests++;
                if (w_row_valid !== R'(1 << (k % R)) || weight_load_ptr !== 1'((k / R) % 2)) begin
                    n_fail++;
                    $display("FAIL wload_row: beat %0d got row=%b ptr=%b want row=%b ptr=%0d",
                             k, w_row_valid, weight_load_ptr, R'(1 << (k % R)), (k / R) % 2);
                end
                n_tests++;
                if (w_row_data !== e_wrd) begin
                    n_fail++;
                    $display("FAIL wload_data: beat %0d got %h want %h", k, w_row_data, e_wrd);
                end
                k++;
            end
            advance();
        end
        w_valid = 0;
        n_tests++;
        if (k != 8) begin
            n_fail++;
            $display("FAIL wload_beats: got %0d rows written want 8", k);
        end else begin
            n_tests++;
            if (beat_c[3] - beat_c[0] != 3 || beat_c[7] - beat_c[4] != 3) begin
                n_fail++;
                $display("FAIL wload_consecutive: got spans %0d/%0d want 3/3",
                         beat_c[3] - beat_c[0], beat_c[7] - beat_c[4]);
            end
        end
        repeat (2) begin
            @(negedge s_clk);
            n_tests++;
            if (w_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL both_full: got w_ready=%b busy=%b want 0/1", w_ready, busy);
            end
            advance();
        end
    endtask

    task automatic test_stream_release();
        int acc[$];
        int lane_first [R];
        int done_c = -1;
        int sent = 0;
        logic [R*DW-1:0] vec;
        for (int r = 0; r < R; r++) begin
            lane_first[r] = -1;
            vec[DW*r +: DW] = DW'(r + 1);
        end
        w_valid = 1;
        for (int n = 0; n < 40; n++) begin
            w_data    = $urandom;
            act_valid = (sent < 3);
            act_last  = (sent == 2);
            act_data  = vec;
            @(negedge s_clk);
            if (act_valid && act_ready) begin
                acc.push_back(cyc);
                sent++;
            end
            for (int r = 0; r < R; r++)
                if (a_row_valid[r]) begin
                    if (lane_first[r] < 0) lane_first[r] = cyc;
                    n_tests++;
                    if (a_row_data[DW*r +: DW] !== DW'(r + 1)) begin
                        n_fail++;
                        $display("FAIL stream_lane_data: lane %0d got %h want %h",
                                 r, a_row_data[DW*r +: DW], r + 1);
                    end
                end
            if (tile_done && done_c < 0) begin
                done_c = cyc;
                n_tests++;
                if (weight_calc_ptr !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_ptr_toggle: got %b want 1", weight_calc_ptr);
                end
            end else if (done_c < 0) begin
                n_tests++;
                if (weight_calc_ptr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_ptr_hold: cyc %0d got %b want 0", cyc, weight_calc_ptr);
                end
            end
            if (done_c < 0 || cyc == done_c) begin
                n_tests++;
                if (w_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_ready: cyc %0d got %b want 0", cyc, w_ready);
                end
            end else if (cyc == done_c + 1) begin
                n_tests++;
                if (w_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL release_ready: got %b want 1", w_ready);
                end
            end else if (cyc == done_c + 2) begin
                n_tests++;
                if (w_row_valid !== R'(1) || weight_load_ptr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL release_load: got row=%b ptr=%b want 0001/0", w_row_valid, weight_load_ptr);
                end
            end
            advance();
        end
        w_valid = 0; act_valid = 0; act_last = 0;
        n_tests++;
        if (acc.size() != 3 || done_c < 0) begin
            n_fail++;
            $display("FAIL stream_events: got %0d accepts done=%0d want 3 and a tile_done", acc.size(), done_c);
        end else begin
            n_tests++;
            if (acc[1] != acc[0] + 1 || acc[2] != acc[0] + 2) begin
                n_fail++;
                $display("FAIL stream_rate: got accepts %0d,%0d,%0d want consecutive", acc[0], acc[1], acc[2]);
            end
            for (int r = 0; r < R; r++) begin
                n_tests++;
                if (lane_first[r] != acc[0] + 1 + r) begin
                    n_fail++;
                    $display("FAIL stream_skew: lane %0d got cycle %0d want %0d", r, lane_first[r], acc[0] + 1 + r);
                end
            end
            n_tests++;
            if (done_c != acc[2] + DL + 1) begin
                n_fail++;
                $display("FAIL stream_done_time: got %0d want %0d", done_c, acc[2] + DL + 1);
            end
        end
    endtask

    task automatic test_single_vector();
        int t = -1;
        int done_c = -1;
        act_data = $urandom;
        for (int n = 0; n < 30; n++) begin
            act_valid = (t < 0);
            act_last  = 1;
            @(negedge s_clk);
            if (t < 0 && act_valid && act_ready) t = cyc;
            else if (t >= 0 && cyc == t + 1) begin
                n_tests++;
                if (act_ready !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_drain: got act_ready=%b busy=%b want 0/1", act_ready, busy);
                end
            end
            if (t >= 0 && cyc > t && done_c < 0) begin
                if (tile_done) begin
                    done_c = cyc;
                    n_tests++;
                    if (weight_calc_ptr !== 1'b0) begin
                        n_fail++;
                        $display("FAIL single_ptr: got %b want 0", weight_calc_ptr);
                    end
                end else begin
                    n_tests++;
                    if (weight_calc_ptr !== 1'b1) begin
                        n_fail++;
                        $display("FAIL single_ptr_hold: got %b want 1", weight_calc_ptr);
                    end
                end
            end
            advance();
        end
        act_valid = 0; act_last = 0;
        n_tests++;
        if (t < 0 || done_c != t + DL + 1) begin
            n_fail++;
            $display("FAIL single_done_time: got accept %0d done %0d want done=accept+%0d", t, done_c, DL + 1);
        end
    endtask

    task automatic test_random();
        logic [R-1:0] exp_v;
        bit bad;
        int slot;
        for (int n = 0; n < 800; n++) begin
            w_valid   = ($urandom_range(0, 3) != 0);
            w_data    = $urandom;
            act_valid = $urandom_range(0, 1) == 1;
            act_last  = ($urandom_range(0, 3) == 0);
            act_data  = $urandom;
            @(negedge s_clk);
            slot = cyc % 32;
            n_tests++;
            if (w_ready !== m_loading || act_ready !== m_act_ready() || busy !== m_busy()) begin
                n_fail++;
                $display("FAIL rand_ready: cyc %0d got w/a/busy=%b%b%b want %b%b%b",
                         cyc, w_ready, act_ready, busy, m_loading, m_act_ready(), m_busy());
            end
            n_tests++;
            if (w_row_valid !== e_wrv || weight_load_ptr !== e_lptr ||
                (e_wrv != '0 && w_row_data !== e_wrd)) begin
                n_fail++;
                $display("FAIL rand_wload: cyc %0d got row=%b ptr=%b data=%h want row=%b ptr=%b data=%h",
                         cyc, w_row_valid, weight_load_ptr, w_row_data, e_wrv, e_lptr, e_wrd);
            end
            n_tests++;
            if (tile_done !== e_done || weight_calc_ptr !== m_cbank) begin
                n_fail++;
                $display("FAIL rand_calc: cyc %0d got done=%b ptr=%b want done=%b ptr=%b",
                         cyc, tile_done, weight_calc_ptr, e_done, m_cbank);
            end
            bad = 0;
            for (int r = 0; r < R; r++) begin
                exp_v[r] = s_v[slot][r];
                if (s_v[slot][r] && a_row_data[DW*r +: DW] !== s_d[slot][r]) bad = 1;
            end
            n_tests++;
            if (a_row_valid !== exp_v || bad) begin
                n_fail++;
                $display("FAIL rand_lanes: cyc %0d got valid=%b data=%h want valid=%b", cyc, a_row_valid, a_row_data, exp_v);
            end
            advance();
        end
        w_valid = 0; act_valid = 0; act_last = 0;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int seen = -1;
        act_valid = 0; act_last = 0; w_valid = 1;
        while (!(m_phase == 0 && m_full[m_cbank]) && guard < 200) begin
            w_data = $urandom;
            @(negedge s_clk);
            advance();
            guard++;
        end
        w_valid = 0;
        n_tests++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL midrst_setup: got no ready bank within 200 cycles want one");
        end
        for (int i = 0; i < 3; i++) begin
            act_valid = (i < 2);
            act_data  = $urandom;
            @(negedge s_clk);
            advance();
        end
        act_valid = 0;
        n_tests++;
        if (a_row_valid === '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: got a_row_valid=%b busy=%b want nonzero/1", a_row_valid, busy);
        end
        s_rst = 1;
        #1;
        n_tests++;
        if ({w_ready, act_ready, weight_load_ptr, weight_calc_ptr, tile_done, busy} !== 6'b0 ||
            w_row_valid !== '0 || a_row_valid !== '0 || w_row_data !== '0 || a_row_data !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got ctrl=%b wrv=%b arv=%b wrd=%h ard=%h want all 0",
                     {w_ready, act_ready, weight_load_ptr, weight_calc_ptr, tile_done, busy},
                     w_row_valid, a_row_valid, w_row_data, a_row_data);
        end
        @(posedge s_clk); #1;
        s_rst = 0;
        mreset();
        w_valid = 1;
        w_data  = 32'hA5C3_1E77;
        for (int n = 0; n < 6 && seen < 0; n++) begin
            @(negedge s_clk);
            if (w_row_valid !== '0) begin
                seen = cyc;
                n_tests++;
                if (w_row_valid !== R'(1) || weight_load_ptr !== 1'b0 || w_row_data !== 32'hA5C3_1E77) begin
                    n_fail++;
                    $display("FAIL midrst_first_beat: got row=%b ptr=%b data=%h want 0001/0/a5c31e77",
                             w_row_valid, weight_load_ptr, w_row_data);
                end
            end
            advance();
        end
        w_valid = 0;
        n_tests++;
        if (seen < 0) begin
            n_fail++;
            $display("FAIL midrst_no_beat: got no w_row_valid within 6 cycles want one");
        end
    endtask

    initial begin
        mreset();
        test_reset();
        test_no_bank();
        test_weight_load();
        test_stream_release();
        test_single_vector();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
